// File: rtl/mean_accumulator.sv
// -----------------------------------------------------------------------------
// mean_accumulator
//
// Accumulates unsigned pixel samples over a window closed by frame_end and
// hands the window sum and sample count to an external divider. The divider's
// quotient is reported as the frame mean. Only one division is in flight at a
// time: a window that closes while a division is outstanding is discarded,
// and a divider that never answers is abandoned after TIMEOUT cycles.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   pix_v         sample valid
//   pix_data      unsigned sample (DATA_W)
//   frame_end     one-cycle pulse closing the current window; a sample that is
//                 valid in the same cycle belongs to the closing window
//   div_start     one-cycle launch pulse to the divider
//   div_dividend  window sum, held from launch until the next launch
//   div_divisor   window sample count, held from launch until the next launch
//   div_quotient  divider result
//   div_qv        one-cycle divider result-valid pulse
//   mean          last reported mean, held until the next report
//   mean_v        one-cycle report pulse
//   busy          high while a division is outstanding
//   ovf           the reported window saturated its sum or count
//   zero_frame    the reported window had no samples
//   frame_drop    one-cycle pulse when a closing window is discarded
//   timeout_err   one-cycle pulse when the divider fails to answer
// -----------------------------------------------------------------------------
module mean_accumulator #(
  parameter int DATA_W     = 8,
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 20,
  parameter int QUOTIENT_W = 28,
  parameter int TIMEOUT    = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_v,
  input  logic [DATA_W-1:0]     pix_data,
  input  logic                  frame_end,
  output logic                  div_start,
  output logic [DIVIDEND_W-1:0] div_dividend,
  output logic [DIVISOR_W-1:0]  div_divisor,
  input  logic [QUOTIENT_W-1:0] div_quotient,
  input  logic                  div_qv,
  output logic [QUOTIENT_W-1:0] mean,
  output logic                  mean_v,
  output logic                  busy,
  output logic                  ovf,
  output logic                  zero_frame,
  output logic                  frame_drop,
  output logic                  timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  // Running window accumulators.
  logic [DIVIDEND_W-1:0] sum;
  logic [DIVISOR_W-1:0]  cnt;
  logic                  sat;

  // Saturation flag of the window currently being divided.
  logic                  snap_sat;

  // Cycles spent in WAIT since the launch.
  logic [WAIT_W-1:0]     wait_cnt;

  // Accumulator values including this cycle's sample.
  logic [DIVIDEND_W:0]   sum_ext;
  logic [DIVIDEND_W-1:0] sum_post;
  logic [DIVISOR_W-1:0]  cnt_post;
  logic                  sat_post;

  // Per-cycle decisions from the control process.
  logic close_win;
  logic launch;
  logic report_div;
  logic report_zero;
  logic drop;
  logic tmo;

  // ---------------------------------------------------------------------------
  // Post-update accumulator values. Both sum and count clamp at all-ones and
  // remember that they did so; the flag travels with the window to its report.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sum_ext  = '0;
    sum_post = sum;
    cnt_post = cnt;
    sat_post = sat;
    if (pix_v) begin
      sum_ext = {1'b0, sum} + (DIVIDEND_W + 1)'(pix_data);
      if (sum_ext[DIVIDEND_W]) begin
        sum_post = '1;
        sat_post = 1'b1;
      end else begin
        sum_post = sum_ext[DIVIDEND_W-1:0];
      end
      if (cnt == '1) begin
        sat_post = 1'b1;
      end else begin
        cnt_post = cnt + DIVISOR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state and per-cycle decisions.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state;
    close_win   = 1'b0;
    launch      = 1'b0;
    report_div  = 1'b0;
    report_zero = 1'b0;
    drop        = 1'b0;
    tmo         = 1'b0;

    unique case (state)
      IDLE: begin
        if (frame_end) begin
          close_win = 1'b1;
          if (cnt_post != '0) begin
            launch  = 1'b1;
            state_d = WAIT;
          end else begin
            // Empty window: report a zero mean without involving the divider.
            report_zero = 1'b1;
          end
        end
      end

      WAIT: begin
        if (frame_end) begin
          close_win = 1'b1;
          drop      = 1'b1;
        end
        if (div_qv) begin
          report_div = 1'b1;
          state_d    = DONE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end

      DONE: begin
        // A window closing during the single reporting cycle cannot launch,
        // because launches happen only from IDLE; it is discarded like one
        // closing during WAIT.
        if (frame_end) begin
          close_win = 1'b1;
          drop      = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator. A closing window clears the registers; a sample in the next
  // cycle then lands on the cleared values and starts the new window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (close_win) begin
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      sum <= sum_post;
      cnt <= cnt_post;
      sat <= sat_post;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait counter: zero in the launch cycle, counting while WAIT persists.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (launch) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !report_div && !tmo) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Divider interface and report registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      snap_sat     <= 1'b0;
      mean         <= '0;
      mean_v       <= 1'b0;
      ovf          <= 1'b0;
      zero_frame   <= 1'b0;
      frame_drop   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      div_start   <= launch;
      mean_v      <= report_div | report_zero;
      frame_drop  <= drop;
      timeout_err <= tmo;

      // The operands stay put until the next launch so a slow divider may
      // sample them at any point while the division is outstanding.
      if (launch) begin
        div_dividend <= sum_post;
        div_divisor  <= cnt_post;
        snap_sat     <= sat_post;
      end

      if (report_div) begin
        mean       <= div_quotient;
        ovf        <= snap_sat;
        zero_frame <= 1'b0;
      end else if (report_zero) begin
        mean       <= '0;
        ovf        <= 1'b0;
        zero_frame <= 1'b1;
      end
    end
  end

  assign busy = (state == WAIT);

endmodule

// File: tb/tb_mean_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mean_accumulator
//
// Directed bench for mean_accumulator. The bench plays the divider by hand.
// A second, narrow instance exercises sum saturation in a handful of cycles.
// -----------------------------------------------------------------------------
module tb_mean_accumulator;

  localparam int DATA_W     = 8;
  localparam int DIVIDEND_W = 28;
  localparam int DIVISOR_W  = 20;
  localparam int QUOTIENT_W = 28;
  localparam int TIMEOUT    = 512;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;

  logic                  pix_v = 1'b0;
  logic [DATA_W-1:0]     pix_data = '0;
  logic                  frame_end = 1'b0;
  logic                  div_start;
  logic [DIVIDEND_W-1:0] div_dividend;
  logic [DIVISOR_W-1:0]  div_divisor;
  logic [QUOTIENT_W-1:0] div_quotient = '0;
  logic                  div_qv = 1'b0;
  logic [QUOTIENT_W-1:0] mean;
  logic                  mean_v;
  logic                  busy;
  logic                  ovf;
  logic                  zero_frame;
  logic                  frame_drop;
  logic                  timeout_err;

  // Narrow instance: 10-bit sum, 4-bit count.
  logic                  s_pix_v = 1'b0;
  logic [7:0]            s_pix_data = '0;
  logic                  s_frame_end = 1'b0;
  logic                  s_div_start;
  logic [9:0]            s_div_dividend;
  logic [3:0]            s_div_divisor;
  logic [9:0]            s_div_quotient = '0;
  logic                  s_div_qv = 1'b0;
  logic [9:0]            s_mean;
  logic                  s_mean_v;
  logic                  s_busy;
  logic                  s_ovf;
  logic                  s_zero_frame;
  logic                  s_frame_drop;
  logic                  s_timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mean_accumulator #(
    .DATA_W(DATA_W), .DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W),
    .QUOTIENT_W(QUOTIENT_W), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .pix_v(pix_v), .pix_data(pix_data), .frame_end(frame_end),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv),
    .mean(mean), .mean_v(mean_v), .busy(busy), .ovf(ovf),
    .zero_frame(zero_frame), .frame_drop(frame_drop), .timeout_err(timeout_err)
  );

  mean_accumulator #(
    .DATA_W(8), .DIVIDEND_W(10), .DIVISOR_W(4), .QUOTIENT_W(10), .TIMEOUT(8)
  ) u_small (
    .clk(clk), .rst_n(rst_n),
    .pix_v(s_pix_v), .pix_data(s_pix_data), .frame_end(s_frame_end),
    .div_start(s_div_start), .div_dividend(s_div_dividend), .div_divisor(s_div_divisor),
    .div_quotient(s_div_quotient), .div_qv(s_div_qv),
    .mean(s_mean), .mean_v(s_mean_v), .busy(s_busy), .ovf(s_ovf),
    .zero_frame(s_zero_frame), .frame_drop(s_frame_drop), .timeout_err(s_timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] value);
    pix_v    = 1'b1;
    pix_data = value;
    step();
    pix_v    = 1'b0;
    pix_data = '0;
  endtask

  initial begin
    int n;

    // ---------------- reset state ----------------
    #12;
    check("rst_div_start", div_start, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_mean", mean, 0);
    check("rst_mean_v", mean_v, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {ovf, zero_frame, frame_drop, timeout_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- basic frame 10,20,30,40 ----------------
    sample(8'd10);
    sample(8'd20);
    sample(8'd30);
    sample(8'd40);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("basic_start", div_start, 1);
    check("basic_dividend", div_dividend, 100);
    check("basic_divisor", div_divisor, 4);
    check("basic_busy", busy, 1);
    step();
    check("basic_start_once", div_start, 0);
    check("basic_no_mean_yet", mean_v, 0);
    div_qv = 1'b1;
    div_quotient = 28'd25;
    step();
    div_qv = 1'b0;
    check("basic_mean_v", mean_v, 1);
    check("basic_mean", mean, 25);
    check("basic_ovf", ovf, 0);
    check("basic_busy_done", busy, 0);
    step();
    check("basic_mean_v_pulse", mean_v, 0);
    check("basic_mean_hold", mean, 25);

    // ---------------- empty frame ----------------
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("zero_mean_v", mean_v, 1);
    check("zero_mean", mean, 0);
    check("zero_flag", zero_frame, 1);
    check("zero_no_start", div_start, 0);
    check("zero_not_busy", busy, 0);
    check("zero_operands_hold", div_dividend, 100);

    // ---------------- coincident sample 3,5,(7 + frame_end) ----------------
    sample(8'd3);
    sample(8'd5);
    pix_v = 1'b1;
    pix_data = 8'd7;
    frame_end = 1'b1;
    step();
    pix_v = 1'b0;
    pix_data = '0;
    frame_end = 1'b0;
    check("coin_start", div_start, 1);
    check("coin_dividend", div_dividend, 15);
    check("coin_divisor", div_divisor, 3);
    div_qv = 1'b1;
    div_quotient = 28'd5;
    step();
    div_qv = 1'b0;
    check("coin_mean", mean, 5);
    check("coin_zero_cleared", zero_frame, 0);
    step();
    // Next window must start from zero: a lone 9 gives 9/1.
    sample(8'd9);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("restart_dividend", div_dividend, 9);
    check("restart_divisor", div_divisor, 1);

    // ---------------- frame_end during WAIT ----------------
    sample(8'd1);
    sample(8'd2);
    pix_v = 1'b1;
    pix_data = 8'd4;
    frame_end = 1'b1;
    step();
    pix_v = 1'b0;
    pix_data = '0;
    frame_end = 1'b0;
    check("drop_pulse", frame_drop, 1);
    check("drop_no_start", div_start, 0);
    check("drop_still_busy", busy, 1);
    sample(8'd6);
    check("drop_pulse_once", frame_drop, 0);
    sample(8'd8);
    div_qv = 1'b1;
    div_quotient = 28'd9;
    step();
    div_qv = 1'b0;
    check("drop_mean", mean, 9);
    step();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("carry_start", div_start, 1);
    check("carry_dividend", div_dividend, 14);
    check("carry_divisor", div_divisor, 2);

    // ---------------- divider timeout ----------------
    n = 0;
    while (n < 600 && !timeout_err) begin
      step();
      n++;
      if (mean_v) check("tmo_no_mean_v", mean_v, 0);
    end
    check("tmo_cycles", n, TIMEOUT);
    check("tmo_pulse", timeout_err, 1);
    check("tmo_not_busy", busy, 0);
    check("tmo_mean_hold", mean, 9);
    step();
    check("tmo_pulse_once", timeout_err, 0);
    // Divider answering after abandonment is ignored.
    div_qv = 1'b1;
    div_quotient = 28'd99;
    step();
    div_qv = 1'b0;
    check("late_qv_ignored", mean_v, 0);
    sample(8'd50);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("post_tmo_start", div_start, 1);
    check("post_tmo_dividend", div_dividend, 50);
    check("post_tmo_busy", busy, 1);

    // ---------------- reset mid-WAIT ----------------
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dividend", div_dividend, 0);
    check("mid_rst_divisor", div_divisor, 0);
    check("mid_rst_mean", mean, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    div_qv = 1'b1;
    div_quotient = 28'd77;
    step();
    div_qv = 1'b0;
    check("stale_qv_mean_v", mean_v, 0);
    check("stale_qv_mean", mean, 0);
    check("stale_qv_busy", busy, 0);

    // ---------------- sum saturation on the narrow instance ----------------
    for (int i = 0; i < 5; i++) begin
      s_pix_v = 1'b1;
      s_pix_data = 8'd255;
      step();
    end
    s_pix_v = 1'b0;
    s_pix_data = '0;
    s_frame_end = 1'b1;
    step();
    s_frame_end = 1'b0;
    check("sat_start", s_div_start, 1);
    check("sat_dividend", s_div_dividend, 1023);
    check("sat_divisor", s_div_divisor, 5);
    s_div_qv = 1'b1;
    s_div_quotient = 10'd204;
    step();
    s_div_qv = 1'b0;
    check("sat_mean", s_mean, 204);
    check("sat_ovf", s_ovf, 1);
    step();
    s_pix_v = 1'b1;
    s_pix_data = 8'd1;
    s_frame_end = 1'b1;
    step();
    s_pix_v = 1'b0;
    s_pix_data = '0;
    s_frame_end = 1'b0;
    check("sat_clear_dividend", s_div_dividend, 1);
    s_div_qv = 1'b1;
    s_div_quotient = 10'd1;
    step();
    s_div_qv = 1'b0;
    check("sat_clear_ovf", s_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mean_accumulator.md
MEAN_ACCUMULATOR -- requirements
Module: mean_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning pixel sample width.
REQ-002 The block SHALL have parameter DIVIDEND_W, default 28, meaning sum and dividend width.
REQ-003 The block SHALL have parameter DIVISOR_W, default 20, meaning sample-count and divisor width.
REQ-004 The block SHALL have parameter QUOTIENT_W, default 28, meaning quotient and mean width.
REQ-005 The block SHALL have parameter TIMEOUT, default 512, meaning the maximum number of cycles to wait for div_qv.
REQ-006 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all logic on its rising edge.
  rst_n  in  1  asynchronous active-low reset.
  pix_v  in  1  sample valid.
  pix_data  in  DATA_W  unsigned sample.
  frame_end  in  1  one-cycle pulse closing the current accumulation window.
  div_start  out  1  one-cycle launch pulse to the downstream divider.
  div_dividend  out  DIVIDEND_W  frame sum, held stable from launch until result.
  div_divisor  out  DIVISOR_W  frame sample count, held stable from launch until result.
  div_quotient  in  QUOTIENT_W  divider result.
  div_qv  in  1  one-cycle divider result-valid pulse.
  mean  out  QUOTIENT_W  last frame mean.
  mean_v  out  1  one-cycle mean-valid pulse.
  busy  out  1  high while a division is outstanding.
  ovf  out  1  the reported frame saturated its sum or count.
  zero_frame  out  1  the reported frame had no samples.
  frame_drop  out  1  one-cycle pulse when a frame_end is discarded.
  timeout_err  out  1  one-cycle pulse when the divider fails to answer.

Function
REQ-007 The accumulator SHALL add pix_data, zero-extended, to sum and increment cnt on every cycle with pix_v=1, in every state.
REQ-008 The sum SHALL saturate at 2^DIVIDEND_W-1, cnt SHALL saturate at 2^DIVISOR_W-1, and either saturation SHALL set a per-frame sat flag.
REQ-009 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-010 In IDLE, frame_end=1 with the post-update cnt nonzero SHALL snapshot the post-update sum and cnt into div_dividend and div_divisor, pulse div_start for one cycle at t+1, and enter WAIT.
REQ-011 A sample with pix_v=1 in the same cycle as frame_end SHALL belong to the closing frame.
REQ-012 When a frame closes, the next-cycle sum, cnt and sat SHALL be cleared, or loaded with the single sample if pix_v=1 at t+1.
REQ-013 In IDLE, frame_end with cnt=0 SHALL give mean=0, mean_v=1 and zero_frame=1 at t+1, with no div_start and no state change.
REQ-014 busy SHALL be 1 exactly while the FSM is in WAIT.
REQ-015 In WAIT, a wait counter SHALL count cycles since div_start.
REQ-016 In WAIT, div_qv=1 at cycle u SHALL register mean=div_quotient, mean_v=1 and ovf=sat(snapshot) at u+1, and the FSM SHALL pass through DONE to IDLE.
REQ-017 Only one division SHALL be outstanding at a time; div_start SHALL never assert outside IDLE.
REQ-018 In WAIT, frame_end SHALL close and clear the window as in REQ-012 without launching a division, and SHALL pulse frame_drop at t+1.
REQ-019 div_qv received in IDLE SHALL be ignored.
REQ-020 If the wait counter reaches TIMEOUT without div_qv, the block SHALL pulse timeout_err, SHALL NOT pulse mean_v, and SHALL return to IDLE.
REQ-021 mean, ovf and zero_frame SHALL hold their values until the next report.
REQ-022 div_dividend and div_divisor SHALL hold their values until the next launch.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, clear sum, cnt, sat and the wait counter, and drive every output to 0, including during WAIT.
REQ-024 After reset release, a late div_qv SHALL be ignored per REQ-019.

Verification
REQ-025 Samples 10, 20, 30, 40 then frame_end -> div_dividend=100, div_divisor=4 and a single div_start; div_qv with quotient 25 -> mean=25, mean_v one cycle later.
REQ-026 frame_end with no samples -> mean=0, zero_frame=1, no div_start.
REQ-027 pix_v=1 (value 7) coincident with frame_end after samples 3, 5 -> dividend=15, divisor=3; next-frame sum restarts at 0.
REQ-028 frame_end during WAIT -> frame_drop pulse and no second div_start; samples arriving during WAIT appear in the next launch.
REQ-029 With no div_qv for 512 cycles -> timeout_err pulse, busy=0, and the next frame launches normally.
REQ-030 rst_n low mid-WAIT -> all outputs 0 immediately; a stale div_qv afterwards produces no mean_v.
